// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one partial product per cycle.
// Signed/unsigned per transaction, valid/ready on both sides.
module booth_r4_seq_mul #(
    parameter int W = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic           signed_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product_o,
    output logic           busy_o
);
    localparam int N_PP = W / 2 + 1;
    localparam int AW   = 2 * W + 2;
    localparam int BW   = 2 * N_PP;
    localparam int KW   = $clog2(N_PP + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          cap;
    logic          last;
    logic [AW-1:0] a_q;
    logic [BW:0]   b_q;
    logic [AW-1:0] acc_q;
    logic [KW-1:0] k_q;

    logic [AW-1:0] a_ext;
    logic [BW:0]   b_ext;
    logic [2:0]    trip;
    logic          one, two, neg;
    logic [AW-1:0] mag, addend, sum;

    assign last = (k_q == KW'(N_PP - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy_o    = 1'b0;
        cap       = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        cap     = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // b_q bit 0 holds b[-1]; both operands shift so the digit is always b_q[2:0]
    assign a_ext = {{(AW - W){signed_i & a_i[W-1]}}, a_i};
    assign b_ext = {{(BW - W){signed_i & b_i[W-1]}}, b_i, 1'b0};

    assign trip = b_q[2:0];
    assign one  = trip[0] ^ trip[1];
    assign two  = (trip == 3'b011) | (trip == 3'b100);
    assign neg  = trip[2] & ~(trip[1] & trip[0]);

    always_comb begin
        mag = '0;
        if (one)      mag = a_q;
        else if (two) mag = {a_q[AW-2:0], 1'b0};
    end

    // negative digits: one's complement here, the +1 rides in as carry
    assign addend = neg ? ~mag : mag;
    assign sum    = acc_q + addend + {{(AW - 1){1'b0}}, neg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            product_o <= '0;
        end else if (cap) begin
            a_q   <= a_ext;
            b_q   <= b_ext;
            acc_q <= '0;
            k_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q <= sum;
            a_q   <= {a_q[AW-3:0], 2'b00};
            b_q   <= {2'b00, b_q[BW:2]};
            k_q   <= k_q + KW'(1);
            if (last) product_o <= sum[2*W-1:0];
        end
    end
endmodule
